// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bus of the scoreboarded register file.
// Master drives write, claim and read-index signals; slave returns ready,
// read data and per-port busy bits.
interface regfile_sb_if #(
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned INDEX_WIDTH = 4,
    parameter int unsigned NUM_RD      = 2
);
    logic                          ready;
    logic                          wrtEn0;
    logic [INDEX_WIDTH-1:0]        wrtRegno0;
    logic [WORD_SIZE-1:0]          dataIn0;
    logic                          wrtEn1;
    logic [INDEX_WIDTH-1:0]        wrtRegno1;
    logic [WORD_SIZE-1:0]          dataIn1;
    logic                          claimEn;
    logic [INDEX_WIDTH-1:0]        claimRegno;
    logic [NUM_RD*INDEX_WIDTH-1:0] rdRegno;
    logic [NUM_RD*WORD_SIZE-1:0]   dataOut;
    logic [NUM_RD-1:0]             rdBusy;

    modport master (
        output wrtEn0, wrtRegno0, dataIn0,
        output wrtEn1, wrtRegno1, dataIn1,
        output claimEn, claimRegno, rdRegno,
        input  ready, dataOut, rdBusy
    );

    modport slave (
        input  wrtEn0, wrtRegno0, dataIn0,
        input  wrtEn1, wrtRegno1, dataIn1,
        input  claimEn, claimRegno, rdRegno,
        output ready, dataOut, rdBusy
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read, dual-write register file with a pending-write
// scoreboard and a sequential clear engine run after every reset.
// Optional feature macro: WRITE_BYPASS_EN (same-cycle write-to-read bypass).
module regfile_sb #(
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned INDEX_WIDTH = 4,
    parameter int unsigned NUM_RD      = 2
) (
    input  logic          clk,
    input  logic          reset,
    regfile_sb_if.slave   bus
);
    localparam int unsigned NREGS = 1 << INDEX_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NREGS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                   state;
    logic [INDEX_WIDTH-1:0]   clr_idx;
    logic [NREGS-1:0]         busy;
    logic [NREGS-1:0]         busy_nxt;
    logic                     ready;
    logic [WORD_SIZE-1:0]     mem [NREGS];

    logic [INDEX_WIDTH-1:0]        rd_idx;
    logic [NUM_RD*WORD_SIZE-1:0]   data_c;
    logic [NUM_RD-1:0]             rd_busy_c;

    // Scoreboard update: writes retire a pending result, a claim (newer producer) wins.
    always_comb begin
        busy_nxt = busy;
        if (bus.wrtEn0) busy_nxt[bus.wrtRegno0] = 1'b0;
        if (bus.wrtEn1) busy_nxt[bus.wrtRegno1] = 1'b0;
        if (bus.claimEn) busy_nxt[bus.claimRegno] = 1'b1;
    end

    // Control FSM: walk the clear index once after reset, then accept traffic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            busy    <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_idx <= clr_idx + INDEX_WIDTH'(1);
                    if (clr_idx == LAST_IDX) begin
                        state <= ST_READY;
                        ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    busy <= busy_nxt;
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    // Storage: zeroed one entry per cycle while clearing; port 1 written last so it wins.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else begin
            if (bus.wrtEn0) mem[bus.wrtRegno0] <= bus.dataIn0;
            if (bus.wrtEn1) mem[bus.wrtRegno1] <= bus.dataIn1;
        end
    end

    // Combinational read ports; everything reads as zero until the clear completes.
    always_comb begin
        rd_idx    = '0;
        data_c    = '0;
        rd_busy_c = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_idx = bus.rdRegno[i*INDEX_WIDTH +: INDEX_WIDTH];
            if (state == ST_READY) begin
                data_c[i*WORD_SIZE +: WORD_SIZE] = mem[rd_idx];
                rd_busy_c[i]                     = busy[rd_idx];
`ifdef WRITE_BYPASS_EN
                if (bus.wrtEn1 && (bus.wrtRegno1 == rd_idx)) begin
                    data_c[i*WORD_SIZE +: WORD_SIZE] = bus.dataIn1;
                    rd_busy_c[i] = bus.claimEn && (bus.claimRegno == rd_idx);
                end else if (bus.wrtEn0 && (bus.wrtRegno0 == rd_idx)) begin
                    data_c[i*WORD_SIZE +: WORD_SIZE] = bus.dataIn0;
                    rd_busy_c[i] = bus.claimEn && (bus.claimRegno == rd_idx);
                end
`else
                // Same-cycle writes become visible on the following cycle.
`endif
            end
        end
    end

    assign bus.ready   = ready;
    assign bus.dataOut = data_c;
    assign bus.rdBusy  = rd_busy_c;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed table, hand sequences and random traffic for
// regfile_sb, checked against an array-based reference model.
module tb_regfile_sb;
    localparam int unsigned WS    = 32;
    localparam int unsigned IW    = 4;
    localparam int unsigned NR    = 2;
    localparam int unsigned NREGS = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    regfile_sb_if #(.WORD_SIZE(WS), .INDEX_WIDTH(IW), .NUM_RD(NR)) bus ();

    regfile_sb #(.WORD_SIZE(WS), .INDEX_WIDTH(IW), .NUM_RD(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [WS-1:0]    m_mem [NREGS];
    logic [NREGS-1:0] m_busy;
    bit               m_ready;
    int               m_edges;

    typedef struct {
        logic          we0;
        logic [IW-1:0] w0;
        logic [WS-1:0] d0;
        logic          we1;
        logic [IW-1:0] w1;
        logic [WS-1:0] d1;
        logic          cl;
        logic [IW-1:0] creg;
        logic [IW-1:0] r0;
        logic [IW-1:0] r1;
        logic [WS-1:0] e0;
        logic [WS-1:0] e1;
        logic          eb0;
        logic          eb1;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WS-1:0] exp_data(input logic [IW-1:0] idx);
        if (!m_ready) return '0;
`ifdef WRITE_BYPASS_EN
        if (bus.wrtEn1 && bus.wrtRegno1 == idx) return bus.dataIn1;
        if (bus.wrtEn0 && bus.wrtRegno0 == idx) return bus.dataIn0;
`endif
        return m_mem[idx];
    endfunction

    function automatic logic exp_busy(input logic [IW-1:0] idx);
        if (!m_ready) return 1'b0;
`ifdef WRITE_BYPASS_EN
        if ((bus.wrtEn1 && bus.wrtRegno1 == idx) || (bus.wrtEn0 && bus.wrtRegno0 == idx))
            return bus.claimEn && (bus.claimRegno == idx);
`endif
        return m_busy[idx];
    endfunction

    // Model effect of one rising edge, given the inputs presented before it.
    task automatic model_edge(input logic we0, input logic [IW-1:0] w0, input logic [WS-1:0] d0,
                              input logic we1, input logic [IW-1:0] w1, input logic [WS-1:0] d1,
                              input logic cl, input logic [IW-1:0] creg);
        if (!m_ready) begin
            m_mem[m_edges] = '0;
            m_edges++;
            if (m_edges == int'(NREGS)) m_ready = 1'b1;
        end else begin
            if (we0) m_mem[w0] = d0;
            if (we1) m_mem[w1] = d1;
            if (we0) m_busy[w0] = 1'b0;
            if (we1) m_busy[w1] = 1'b0;
            if (cl)  m_busy[creg] = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_edges = 0;
        m_busy  = '0;
    endtask

    task automatic step();
        logic          s_we0, s_we1, s_cl;
        logic [IW-1:0] s_w0, s_w1, s_creg;
        logic [WS-1:0] s_d0, s_d1;
        s_we0 = bus.wrtEn0; s_w0 = bus.wrtRegno0; s_d0 = bus.dataIn0;
        s_we1 = bus.wrtEn1; s_w1 = bus.wrtRegno1; s_d1 = bus.dataIn1;
        s_cl  = bus.claimEn; s_creg = bus.claimRegno;
        @(posedge clk);
        if (!reset) model_edge(s_we0, s_w0, s_d0, s_we1, s_w1, s_d1, s_cl, s_creg);
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.wrtEn0 = 1'b0; bus.wrtRegno0 = '0; bus.dataIn0 = '0;
        bus.wrtEn1 = 1'b0; bus.wrtRegno1 = '0; bus.dataIn1 = '0;
        bus.claimEn = 1'b0; bus.claimRegno = '0;
    endtask

    task automatic set_rd(input logic [IW-1:0] a, input logic [IW-1:0] b);
        bus.rdRegno = {b, a};
    endtask

    task automatic check_outputs(input string tag);
        logic [IW-1:0] idx;
        chk({tag, "_ready"}, WS'(bus.ready), WS'(m_ready));
        for (int i = 0; i < int'(NR); i++) begin
            idx = bus.rdRegno[i*IW +: IW];
            chk($sformatf("%s_data%0d", tag, i), bus.dataOut[i*WS +: WS], exp_data(idx));
            chk($sformatf("%s_busy%0d", tag, i), WS'(bus.rdBusy[i]), WS'(exp_busy(idx)));
        end
    endtask

    // Step through the clear sequence and confirm ready rises on the 16th edge.
    task automatic wait_ready(input string tag);
        int rise;
        rise = 0;
        for (int e = 1; e <= 40; e++) begin
            step();
            #1;
            check_outputs(tag);
            if (bus.ready === 1'b1) begin
                rise = e;
                break;
            end
        end
        chk({tag, "_ready_edge"}, WS'(rise), WS'(NREGS));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WS-1:0] exp_sc;

        for (int i = 0; i < int'(NREGS); i++) m_mem[i] = '0;
        model_reset();
        set_idle();
        set_rd('0, '0);

        vecs[0] = '{1'b1, 4'd1, 32'd8675309, 1'b0, 4'd0, 32'd0,      1'b0, 4'd0,
                    4'd1, 4'd1, 32'd8675309, 32'd8675309, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 4'd3, 32'h0000AAAA, 1'b1, 4'd3, 32'h00005555, 1'b0, 4'd0,
                    4'd3, 4'd1, 32'h00005555, 32'd8675309, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 4'd4, 32'h44, 1'b1, 4'd5, 32'h55, 1'b0, 4'd0,
                    4'd4, 4'd5, 32'h44, 32'h55, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7,
                    4'd7, 4'd3, 32'h0, 32'h00005555, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h77, 1'b0, 4'd0,
                    4'd7, 4'd7, 32'h77, 32'h77, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 4'd7, 32'h70, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7,
                    4'd7, 4'd4, 32'h70, 32'h44, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd8, 32'h88, 1'b1, 4'd7,
                    4'd7, 4'd8, 32'h70, 32'h88, 1'b1, 1'b0};

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_ready", WS'(bus.ready), WS'(0));
        chk("rst_busy", WS'(bus.rdBusy), WS'(0));
        chk("rst_data0", bus.dataOut[WS-1:0], '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Writes and claims during the clear must be ignored
        bus.wrtEn0 = 1'b1; bus.wrtRegno0 = 4'd2; bus.dataIn0 = 32'd99;
        bus.claimEn = 1'b1; bus.claimRegno = 4'd2;
        set_rd(4'd2, 4'd0);
        wait_ready("clear");
        set_idle();

        // Sweep every index on both ports
        for (int i = 0; i < int'(NREGS); i++) begin
            set_rd(IW'(i), IW'(NREGS - 1 - i));
            #1;
            chk($sformatf("sweep_d0_%0d", i), bus.dataOut[0 +: WS], '0);
            chk($sformatf("sweep_d1_%0d", i), bus.dataOut[WS +: WS], '0);
            chk($sformatf("sweep_busy_%0d", i), WS'(bus.rdBusy), WS'(0));
        end

        // Same-cycle read of a write in flight
        bus.wrtEn0 = 1'b1; bus.wrtRegno0 = 4'd1; bus.dataIn0 = 32'd8675309;
        set_rd(4'd1, 4'd1);
        #1;
`ifdef WRITE_BYPASS_EN
        exp_sc = 32'd8675309;
`else
        exp_sc = 32'd0;
`endif
        chk("same_cycle_rd0", bus.dataOut[0 +: WS], exp_sc);
        chk("same_cycle_rd1", bus.dataOut[WS +: WS], exp_sc);
        check_outputs("same_cycle");
        step();
        set_idle();

        // Directed table: apply one cycle of writes/claims, read back next cycle
        for (int v = 0; v < 7; v++) begin
            bus.wrtEn0 = vecs[v].we0; bus.wrtRegno0 = vecs[v].w0; bus.dataIn0 = vecs[v].d0;
            bus.wrtEn1 = vecs[v].we1; bus.wrtRegno1 = vecs[v].w1; bus.dataIn1 = vecs[v].d1;
            bus.claimEn = vecs[v].cl; bus.claimRegno = vecs[v].creg;
            step();
            set_idle();
            set_rd(vecs[v].r0, vecs[v].r1);
            #1;
            chk($sformatf("vec%0d_d0", v), bus.dataOut[0 +: WS], vecs[v].e0);
            chk($sformatf("vec%0d_d1", v), bus.dataOut[WS +: WS], vecs[v].e1);
            chk($sformatf("vec%0d_b0", v), WS'(bus.rdBusy[0]), WS'(vecs[v].eb0));
            chk($sformatf("vec%0d_b1", v), WS'(bus.rdBusy[1]), WS'(vecs[v].eb1));
        end

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            bus.wrtEn0     = 1'($urandom_range(0, 1));
            bus.wrtRegno0  = IW'($urandom_range(0, NREGS - 1));
            bus.dataIn0    = $urandom;
            bus.wrtEn1     = 1'($urandom_range(0, 1));
            bus.wrtRegno1  = IW'($urandom_range(0, NREGS - 1));
            bus.dataIn1    = $urandom;
            bus.claimEn    = 1'($urandom_range(0, 1));
            bus.claimRegno = IW'($urandom_range(0, NREGS - 1));
            set_rd(IW'($urandom_range(0, NREGS - 1)), IW'($urandom_range(0, NREGS - 1)));
            #1;
            check_outputs($sformatf("rand%0d", n));
            step();
        end
        set_idle();

        // Reset in the middle of operation
        bus.wrtEn0 = 1'b1; bus.wrtRegno0 = 4'd9; bus.dataIn0 = 32'd42;
        bus.claimEn = 1'b1; bus.claimRegno = 4'd9;
        step();
        set_idle();
        set_rd(4'd9, 4'd9);
        #1;
        chk("pre_rst_data", bus.dataOut[0 +: WS], 32'd42);
        chk("pre_rst_busy", WS'(bus.rdBusy[1]), WS'(1));
        #1 reset = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_busy", WS'(bus.rdBusy), WS'(0));
        chk("mid_rst_ready", WS'(bus.ready), WS'(0));
        chk("mid_rst_data", bus.dataOut[0 +: WS], '0);
        @(negedge clk);
        reset = 1'b0;
        wait_ready("reclear");
        set_rd(4'd9, 4'd9);
        #1;
        chk("post_rst_data", bus.dataOut[0 +: WS], '0);
        chk("post_rst_busy", WS'(bus.rdBusy), WS'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
